// File: rtl/mbist_def.sv
// Shared MBIST definitions: fail-table sizing, fail-table entry layout and
// the saturation point of the total-mismatch counter.
package mbist_def;

    localparam int BIST_ERR_LIMIT = 4;
    localparam int MBIST_ADDR_WD  = 9;
    localparam int FAIL_CNT_MAX   = 255;

    typedef struct packed {
        logic                     valid;
        logic [MBIST_ADDR_WD-1:0] addr;
    } fail_entry_t;

endpackage

// File: rtl/mbist_rd_align.sv
// DEPTH-deep shift pipeline that delays a read's {vld, addr, exp, mask} so it
// lines up with the SRAM read data; flush drops every in-flight read.
module mbist_rd_align #(
    parameter int ADDR_WD = 9,
    parameter int DATA_WD = 32,
    parameter int DEPTH   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_vld,
    input  logic [ADDR_WD-1:0] in_addr,
    input  logic [DATA_WD-1:0] in_exp,
    input  logic [DATA_WD-1:0] in_mask,
    output logic               out_vld,
    output logic [ADDR_WD-1:0] out_addr,
    output logic [DATA_WD-1:0] out_exp,
    output logic [DATA_WD-1:0] out_mask
);

    logic               vld_q  [DEPTH];
    logic [ADDR_WD-1:0] addr_q [DEPTH];
    logic [DATA_WD-1:0] exp_q  [DEPTH];
    logic [DATA_WD-1:0] mask_q [DEPTH];

    // Payload is cleared along with vld so a flushed pipe holds no stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_q[i]  <= 1'b0;
                addr_q[i] <= '0;
                exp_q[i]  <= '0;
                mask_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_q[i]  <= 1'b0;
                addr_q[i] <= '0;
                exp_q[i]  <= '0;
                mask_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= in_vld;
            addr_q[0] <= in_addr;
            exp_q[0]  <= in_exp;
            mask_q[0] <= in_mask;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
                exp_q[i]  <= exp_q[i-1];
                mask_q[i] <= mask_q[i-1];
            end
        end
    end

    assign out_vld  = vld_q[DEPTH-1];
    assign out_addr = addr_q[DEPTH-1];
    assign out_exp  = exp_q[DEPTH-1];
    assign out_mask = mask_q[DEPTH-1];

endmodule

// File: rtl/mbist_err_capture.sv
// MBIST error capture: aligns reads with SRAM data, compares under mask, and
// reports each failing address once while keeping sticky status and counters.
module mbist_err_capture
    import mbist_def::*;
#(
    parameter int BIST_ADDR_WD = MBIST_ADDR_WD,
    parameter int BIST_DATA_WD = 32,
    parameter int READ_LAT     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    bist_start,
    input  logic                    rd_en,
    input  logic [BIST_ADDR_WD-1:0] rd_addr,
    input  logic [BIST_DATA_WD-1:0] exp_data,
    input  logic [BIST_DATA_WD-1:0] cmp_mask,
    input  logic [BIST_DATA_WD-1:0] rdata,
    output logic                    Error,
    output logic [BIST_ADDR_WD-1:0] ErrorAddr,
    output logic                    bist_fail,
    output logic                    err_overflow,
    output logic [7:0]              fail_cnt,
    output logic [3:0]              uniq_cnt
);

    logic                    vld_c;
    logic [BIST_ADDR_WD-1:0] addr_c;
    logic [BIST_DATA_WD-1:0] exp_c;
    logic [BIST_DATA_WD-1:0] mask_c;
    logic                    mismatch;
    logic                    table_hit;
    logic                    table_full;

    fail_entry_t fail_table [BIST_ERR_LIMIT];

    mbist_rd_align #(
        .ADDR_WD (BIST_ADDR_WD),
        .DATA_WD (BIST_DATA_WD),
        .DEPTH   (READ_LAT)
    ) u_rd_align (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (bist_start),
        .in_vld   (rd_en),
        .in_addr  (rd_addr),
        .in_exp   (exp_data),
        .in_mask  (cmp_mask),
        .out_vld  (vld_c),
        .out_addr (addr_c),
        .out_exp  (exp_c),
        .out_mask (mask_c)
    );

    // vld_c gates the compare so X on rdata in idle cycles cannot propagate.
    assign mismatch   = vld_c && (|((rdata ^ exp_c) & mask_c));
    assign table_full = (uniq_cnt >= 4'(BIST_ERR_LIMIT));

    always_comb begin
        table_hit = 1'b0;
        for (int i = 0; i < BIST_ERR_LIMIT; i++) begin
            if (fail_table[i].valid && (fail_table[i].addr == addr_c)) begin
                table_hit = 1'b1;
            end
        end
    end

    // A table write here is visible to the very next compare, so back-to-back
    // fails on one address produce a single Error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Error        <= 1'b0;
            ErrorAddr    <= '0;
            bist_fail    <= 1'b0;
            err_overflow <= 1'b0;
            fail_cnt     <= '0;
            uniq_cnt     <= '0;
            for (int i = 0; i < BIST_ERR_LIMIT; i++) begin
                fail_table[i] <= '0;
            end
        end else if (bist_start) begin
            Error        <= 1'b0;
            ErrorAddr    <= '0;
            bist_fail    <= 1'b0;
            err_overflow <= 1'b0;
            fail_cnt     <= '0;
            uniq_cnt     <= '0;
            for (int i = 0; i < BIST_ERR_LIMIT; i++) begin
                fail_table[i] <= '0;
            end
        end else begin
            Error <= 1'b0;
            if (mismatch) begin
                bist_fail <= 1'b1;
                if (fail_cnt != 8'(FAIL_CNT_MAX)) begin
                    fail_cnt <= fail_cnt + 8'd1;
                end
                if (!table_hit) begin
                    if (!table_full) begin
                        Error     <= 1'b1;
                        ErrorAddr <= addr_c;
                        uniq_cnt  <= uniq_cnt + 4'd1;
                        for (int i = 0; i < BIST_ERR_LIMIT; i++) begin
                            if (uniq_cnt == 4'(i)) begin
                                fail_table[i] <= '{valid: 1'b1, addr: addr_c};
                            end
                        end
                    end else begin
                        err_overflow <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mbist_err_capture.sv
// Directed bench for mbist_err_capture: one instance at READ_LAT=1 carries
// most vectors, a second at READ_LAT=3 checks the deeper alignment.
module tb_mbist_err_capture;
    import mbist_def::*;

    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bist_start;

    logic        rd_en1;
    logic [8:0]  rd_addr1;
    logic [31:0] exp_data1, cmp_mask1, rdata1;
    logic        err1, fail1, ovf1;
    logic [8:0]  err_addr1;
    logic [7:0]  fail_cnt1;
    logic [3:0]  uniq_cnt1;

    logic        rd_en3;
    logic [8:0]  rd_addr3;
    logic [31:0] exp_data3, cmp_mask3, rdata3;
    logic        err3, fail3, ovf3;
    logic [8:0]  err_addr3;
    logic [7:0]  fail_cnt3;
    logic [3:0]  uniq_cnt3;

    int check_count = 0;
    int pass_count  = 0;
    int pulse_cnt1  = 0;

    always #5 clk = ~clk;

    mbist_err_capture #(.BIST_ADDR_WD(9), .BIST_DATA_WD(32), .READ_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bist_start(bist_start),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .exp_data(exp_data1),
        .cmp_mask(cmp_mask1), .rdata(rdata1),
        .Error(err1), .ErrorAddr(err_addr1), .bist_fail(fail1),
        .err_overflow(ovf1), .fail_cnt(fail_cnt1), .uniq_cnt(uniq_cnt1)
    );

    mbist_err_capture #(.BIST_ADDR_WD(9), .BIST_DATA_WD(32), .READ_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bist_start(bist_start),
        .rd_en(rd_en3), .rd_addr(rd_addr3), .exp_data(exp_data3),
        .cmp_mask(cmp_mask3), .rdata(rdata3),
        .Error(err3), .ErrorAddr(err_addr3), .bist_fail(fail3),
        .err_overflow(ovf3), .fail_cnt(fail_cnt3), .uniq_cnt(uniq_cnt3)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end else begin
            pass_count++;
        end
    endtask

    // Drives one cycle on the READ_LAT=1 instance; rdat is the SRAM data for
    // the read issued in the previous cycle. Outputs are sampled #1 after the edge.
    task automatic applyStimulus(input logic en, input logic [8:0] addr, input logic [31:0] expd,
                                 input logic [31:0] mask, input logic [31:0] rdat, input logic start);
        rd_en1     = en;
        rd_addr1   = addr;
        exp_data1  = expd;
        cmp_mask1  = mask;
        rdata1     = rdat;
        bist_start = start;
        @(posedge clk);
        #1;
        if (err1 === 1'b1) pulse_cnt1++;
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_err"},   32'(err1),      32'd0);
        checkOutput({tag, "_addr"},  32'(err_addr1), 32'd0);
        checkOutput({tag, "_fail"},  32'(fail1),     32'd0);
        checkOutput({tag, "_ovf"},   32'(ovf1),      32'd0);
        checkOutput({tag, "_fcnt"},  32'(fail_cnt1), 32'd0);
        checkOutput({tag, "_ucnt"},  32'(uniq_cnt1), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; bist_start = 1'b0;
        rd_en1 = 1'b0; rd_addr1 = '0; exp_data1 = '0; cmp_mask1 = '0; rdata1 = '0;
        rd_en3 = 1'b0; rd_addr3 = '0; exp_data3 = '0; cmp_mask3 = '0; rdata3 = '0;
        #12;
        checkCleared("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Passing read
        applyStimulus(1'b1, 9'h010, 32'hA5A5_A5A5, ONES, 32'h0, 1'b0);
        applyStimulus(1'b0, 9'h000, 32'h0, 32'h0, 32'hA5A5_A5A5, 1'b0);
        applyStimulus(1'b0, 9'h000, 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("pass_err",  32'(err1),      32'd0);
        checkOutput("pass_fail", 32'(fail1),     32'd0);
        checkOutput("pass_fcnt", 32'(fail_cnt1), 32'd0);

        // Single failing read: Error visible in cycle t+2
        applyStimulus(1'b1, 9'h010, 32'hA5A5_A5A5, ONES, 32'h0, 1'b0);
        checkOutput("fail1_early", 32'(err1), 32'd0);
        applyStimulus(1'b0, 9'h000, 32'h0, 32'h0, 32'hA5A5_A5A4, 1'b0);
        checkOutput("fail1_err",  32'(err1),      32'd1);
        checkOutput("fail1_addr", 32'(err_addr1), 32'h010);
        checkOutput("fail1_ucnt", 32'(uniq_cnt1), 32'd1);
        checkOutput("fail1_fcnt", 32'(fail_cnt1), 32'd1);
        checkOutput("fail1_fail", 32'(fail1),     32'd1);
        applyStimulus(1'b0, 9'h000, 32'h0, 32'h0, 32'hxxxx_xxxx, 1'b0);
        checkOutput("fail1_pulse", 32'(err1),      32'd0);
        checkOutput("fail1_hold",  32'(err_addr1), 32'h010);
        checkOutput("xdata_fcnt",  32'(fail_cnt1), 32'd1);

        // Clear, then three back-to-back fails on one address
        applyStimulus(1'b0, 9'h000, 32'h0, 32'h0, 32'h0, 1'b1);
        checkCleared("start");
        pulse_cnt1 = 0;
        applyStimulus(1'b1, 9'h020, 32'h0, ONES, 32'h0, 1'b0);
        applyStimulus(1'b1, 9'h020, 32'h0, ONES, 32'h1, 1'b0);
        applyStimulus(1'b1, 9'h020, 32'h0, ONES, 32'h1, 1'b0);
        applyStimulus(1'b0, 9'h000, 32'h0, 32'h0, 32'h1, 1'b0);
        applyStimulus(1'b0, 9'h000, 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("b2b_pulses", 32'(pulse_cnt1), 32'd1);
        checkOutput("b2b_fcnt",   32'(fail_cnt1),  32'd3);
        checkOutput("b2b_ucnt",   32'(uniq_cnt1),  32'd1);

        // Masked bit, then fill the table and overflow it
        applyStimulus(1'b0, 9'h000, 32'h0, 32'h0, 32'h0, 1'b1);
        pulse_cnt1 = 0;
        applyStimulus(1'b1, 9'h030, 32'h0, 32'hFFFF_FFFE, 32'h0, 1'b0);
        applyStimulus(1'b1, 9'h001, 32'h0, ONES, 32'h1, 1'b0);
        checkOutput("mask_fail", 32'(fail1), 32'd0);
        checkOutput("mask_err",  32'(err1),  32'd0);
        for (int a = 2; a <= BIST_ERR_LIMIT + 1; a++) begin
            applyStimulus(1'b1, 9'(a), 32'h0, ONES, 32'h1, 1'b0);
            checkOutput("fill_ovf_early", 32'(ovf1), 32'd0);
        end
        applyStimulus(1'b0, 9'h000, 32'h0, 32'h0, 32'h1, 1'b0);
        checkOutput("ovf_lastpulse", 32'(err1), 32'd0);
        applyStimulus(1'b0, 9'h000, 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("ovf_pulses", 32'(pulse_cnt1), 32'(BIST_ERR_LIMIT));
        checkOutput("ovf_flag",   32'(ovf1),       32'd1);
        checkOutput("ovf_ucnt",   32'(uniq_cnt1),  32'(BIST_ERR_LIMIT));
        checkOutput("ovf_addr",   32'(err_addr1),  32'(BIST_ERR_LIMIT));
        checkOutput("ovf_fcnt",   32'(fail_cnt1),  32'(BIST_ERR_LIMIT + 1));

        // bist_start coinciding with a failing compare
        pulse_cnt1 = 0;
        applyStimulus(1'b1, 9'h040, 32'h0, ONES, 32'h0, 1'b0);
        applyStimulus(1'b0, 9'h000, 32'h0, 32'h0, 32'h1, 1'b1);
        checkCleared("startcmp");
        applyStimulus(1'b0, 9'h000, 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("startcmp_next", 32'(err1), 32'd0);

        // bist_start coinciding with rd_en
        applyStimulus(1'b1, 9'h050, 32'h0, ONES, 32'h0, 1'b1);
        applyStimulus(1'b0, 9'h000, 32'h0, 32'h0, 32'h1, 1'b0);
        applyStimulus(1'b0, 9'h000, 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("startrd_pulses", 32'(pulse_cnt1), 32'd0);
        checkOutput("startrd_fcnt",   32'(fail_cnt1),  32'd0);

        // Reset mid-stream with a read in flight
        applyStimulus(1'b1, 9'h060, 32'h0, ONES, 32'h0, 1'b0);
        applyStimulus(1'b1, 9'h070, 32'h0, ONES, 32'h1, 1'b0);
        checkOutput("midrst_pre", 32'(err1), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkCleared("midrst");
        pulse_cnt1 = 0;
        applyStimulus(1'b0, 9'h000, 32'h0, 32'h0, 32'h1, 1'b0);
        #2 rst_n = 1'b1;
        applyStimulus(1'b0, 9'h000, 32'h0, 32'h0, 32'h1, 1'b0);
        applyStimulus(1'b0, 9'h000, 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("midrst_stale", 32'(pulse_cnt1), 32'd0);
        checkOutput("midrst_fcnt",  32'(fail_cnt1),  32'd0);

        // READ_LAT=3: reads 0x100..0x104, only 0x102 returns bad data
        for (int c = 0; c < 9; c++) begin
            rd_en3    = (c < 5);
            rd_addr3  = 9'(32'h100 + c);
            exp_data3 = 32'h1000_0000 | (32'h100 + c);
            cmp_mask3 = ONES;
            if (c >= 3 && c < 8) begin
                rdata3 = 32'h1000_0000 | (32'h100 + c - 3);
                if (c == 5) rdata3 = rdata3 ^ 32'h0000_8000;
            end else begin
                rdata3 = 32'hxxxx_xxxx;
            end
            @(posedge clk); #1;
            checkOutput($sformatf("lat3_err_c%0d", c), 32'(err3), (c == 5) ? 32'd1 : 32'd0);
            if (c == 5) checkOutput("lat3_addr", 32'(err_addr3), 32'h102);
        end
        rd_en3 = 1'b0;
        rdata3 = '0;
        checkOutput("lat3_fcnt", 32'(fail_cnt3), 32'd1);
        checkOutput("lat3_ucnt", 32'(uniq_cnt3), 32'd1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
